// File: rtl/rptr_empty_if.sv
// Read-side FIFO bus between the read controller and the rptr_empty pointer block.
// The master drives requests and the synchronized write pointer, and the slave returns pointer and status.
interface rptr_empty_if #(
  parameter int ADDRSIZE = 2
);
  logic                rinc;
  logic [ADDRSIZE:0]   rq2_wptr;
  logic [ADDRSIZE-1:0] raddr;
  logic [ADDRSIZE:0]   rptr;
  logic                rempty;
  logic [ADDRSIZE:0]   rlevel;
  logic                ralmost_empty;
  logic                runderflow;

  modport master (
    output rinc, rq2_wptr,
    input  raddr, rptr, rempty, rlevel, ralmost_empty, runderflow
  );

  modport slave (
    input  rinc, rq2_wptr,
    output raddr, rptr, rempty, rlevel, ralmost_empty, runderflow
  );
endinterface

// File: rtl/rptr_empty.sv
// Read-side pointer and empty flag for the dual-clock Gray-pointer FIFO, in the rclk domain.
// Define RPTR_LEVEL_EN to build the fill level, almost-empty and underflow logic.
module rptr_empty #(
  parameter int ADDRSIZE  = 2,
  parameter int AE_THRESH = 1
) (
  input  logic        rclk,
  input  logic        rrst_n,
  rptr_empty_if.slave bus
);

  localparam int P = ADDRSIZE + 1;

  logic [P-1:0] rbin;
  logic [P-1:0] rptr_q;
  logic         rempty_q;
  logic         rd_ok;
  logic [P-1:0] rbinnext;
  logic [P-1:0] rgraynext;
  logic         rempty_next;

  assign rd_ok       = bus.rinc & ~rempty_q;
  assign rbinnext    = rbin + {{ADDRSIZE{1'b0}}, rd_ok};
  assign rgraynext   = (rbinnext >> 1) ^ rbinnext;
  assign rempty_next = (rgraynext == bus.rq2_wptr);

  always_ff @(posedge rclk or negedge rrst_n) begin
    if (!rrst_n) begin
      rbin     <= '0;
      rptr_q   <= '0;
      rempty_q <= 1'b1;
    end else begin
      rbin     <= rbinnext;
      rptr_q   <= rgraynext;
      rempty_q <= rempty_next;
    end
  end

  assign bus.raddr  = rbin[ADDRSIZE-1:0];
  assign bus.rptr   = rptr_q;
  assign bus.rempty = rempty_q;

`ifdef RPTR_LEVEL_EN
  localparam logic [P-1:0] AE_LVL = P'(AE_THRESH);

  logic [P-1:0] wbin_s;
  logic [P-1:0] rlevel_next;
  logic [P-1:0] rlevel_q;
  logic         ralmost_q;
  logic         runder_q;

  // Gray to binary: each bit is the XOR of all Gray bits at or above it.
  always_comb begin
    wbin_s           = '0;
    wbin_s[ADDRSIZE] = bus.rq2_wptr[ADDRSIZE];
    for (int i = ADDRSIZE - 1; i >= 0; i--) begin
      wbin_s[i] = wbin_s[i+1] ^ bus.rq2_wptr[i];
    end
  end

  // The level uses the post-read pointer so the consumed entry is already excluded.
  assign rlevel_next = wbin_s - rbinnext;

  always_ff @(posedge rclk or negedge rrst_n) begin
    if (!rrst_n) begin
      rlevel_q  <= '0;
      ralmost_q <= 1'b1;
      runder_q  <= 1'b0;
    end else begin
      rlevel_q  <= rlevel_next;
      ralmost_q <= (rlevel_next <= AE_LVL);
      runder_q  <= bus.rinc & rempty_q;
    end
  end

  assign bus.rlevel        = rlevel_q;
  assign bus.ralmost_empty = ralmost_q;
  assign bus.runderflow    = runder_q;
`else
  assign bus.rlevel        = '0;
  assign bus.ralmost_empty = rempty_q;
  assign bus.runderflow    = 1'b0;
`endif

endmodule

// File: tb/tb_rptr_empty.sv
// Directed bench for rptr_empty (ADDRSIZE=2, AE_THRESH=1); expectations adapt to the RPTR_LEVEL_EN build.
module tb_rptr_empty;

`ifdef RPTR_LEVEL_EN
  localparam bit LEVEL_EN = 1'b1;
`else
  localparam bit LEVEL_EN = 1'b0;
`endif

  logic rclk;
  logic rrst_n;
  int   nvec;
  int   nerr;

  rptr_empty_if #(.ADDRSIZE(2)) bus ();

  rptr_empty #(.ADDRSIZE(2), .AE_THRESH(1)) dut (
    .rclk   (rclk),
    .rrst_n (rrst_n),
    .bus    (bus.slave)
  );

  initial rclk = 1'b0;
  always #5 rclk = ~rclk;

  // {rptr, raddr, rempty, rlevel, ralmost_empty, runderflow}
  logic [10:0] obs;
  assign obs = {bus.rptr, bus.raddr, bus.rempty, bus.rlevel, bus.ralmost_empty, bus.runderflow};

  function automatic logic [10:0] pack_exp(input logic [2:0] rp, input logic [1:0] ra,
                                           input logic re, input logic [2:0] lv,
                                           input logic ae, input logic uf);
    logic [2:0] l;
    logic       a;
    logic       u;
    l = LEVEL_EN ? lv : 3'd0;
    a = LEVEL_EN ? ae : re;
    u = LEVEL_EN ? uf : 1'b0;
    return {rp, ra, re, l, a, u};
  endfunction

  function automatic logic [2:0] gray(input logic [2:0] b);
    return b ^ (b >> 1);
  endfunction

  task automatic step();
    @(posedge rclk);
    #1;
  endtask

  task automatic test_reset();
    logic [10:0] e;
    rrst_n       = 1'b0;
    bus.rinc     = 1'b0;
    bus.rq2_wptr = 3'b000;
    step();
    step();
    rrst_n = 1'b1;
    step();
    e = pack_exp(3'b000, 2'd0, 1'b1, 3'd0, 1'b1, 1'b0);
    nvec++;
    if (obs !== e) begin
      nerr++;
      $display("FAIL reset_state got=%b exp=%b", obs, e);
    end
  endtask

  task automatic test_single();
    logic [10:0] e;
    bus.rq2_wptr = 3'b001;
    step();
    e = pack_exp(3'b000, 2'd0, 1'b0, 3'd1, 1'b1, 1'b0);
    nvec++;
    if (obs !== e) begin
      nerr++;
      $display("FAIL single_write got=%b exp=%b", obs, e);
    end
    bus.rinc = 1'b1;
    step();
    bus.rinc = 1'b0;
    e = pack_exp(3'b001, 2'd1, 1'b1, 3'd0, 1'b1, 1'b0);
    nvec++;
    if (obs !== e) begin
      nerr++;
      $display("FAIL single_read got=%b exp=%b", obs, e);
    end
  endtask

  task automatic test_async_reset();
    logic [10:0] e;
    #2;
    bus.rq2_wptr = 3'b000;
    rrst_n       = 1'b0;
    #1;
    e = pack_exp(3'b000, 2'd0, 1'b1, 3'd0, 1'b1, 1'b0);
    nvec++;
    if (obs !== e) begin
      nerr++;
      $display("FAIL async_reset got=%b exp=%b", obs, e);
    end
    #1;
    rrst_n = 1'b1;
    step();
    nvec++;
    if (obs !== e) begin
      nerr++;
      $display("FAIL post_reset_idle got=%b exp=%b", obs, e);
    end
  endtask

  task automatic test_back_to_back();
    logic [10:0] e;
    logic [2:0]  rp_tab [4] = '{3'b001, 3'b011, 3'b010, 3'b110};
    logic [1:0]  ra_tab [4] = '{2'd1, 2'd2, 2'd3, 2'd0};
    logic [2:0]  lv_tab [4] = '{3'd3, 3'd2, 3'd1, 3'd0};
    logic        re_tab [4] = '{1'b0, 1'b0, 1'b0, 1'b1};
    logic        ae_tab [4] = '{1'b0, 1'b0, 1'b1, 1'b1};
    bus.rq2_wptr = 3'b110;
    step();
    e = pack_exp(3'b000, 2'd0, 1'b0, 3'd4, 1'b0, 1'b0);
    nvec++;
    if (obs !== e) begin
      nerr++;
      $display("FAIL fill_level got=%b exp=%b", obs, e);
    end
    bus.rinc = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      e = pack_exp(rp_tab[i], ra_tab[i], re_tab[i], lv_tab[i], ae_tab[i], 1'b0);
      nvec++;
      if (obs !== e) begin
        nerr++;
        $display("FAIL drain_%0d got=%b exp=%b", i, obs, e);
      end
    end
    bus.rinc = 1'b0;
  endtask

  task automatic test_underflow();
    logic [10:0] e;
    bus.rinc = 1'b1;
    for (int i = 0; i < 2; i++) begin
      step();
      e = pack_exp(3'b110, 2'd0, 1'b1, 3'd0, 1'b1, 1'b1);
      nvec++;
      if (obs !== e) begin
        nerr++;
        $display("FAIL underflow_%0d got=%b exp=%b", i, obs, e);
      end
    end
    bus.rinc = 1'b0;
    step();
    e = pack_exp(3'b110, 2'd0, 1'b1, 3'd0, 1'b1, 1'b0);
    nvec++;
    if (obs !== e) begin
      nerr++;
      $display("FAIL underflow_clear got=%b exp=%b", obs, e);
    end
  endtask

  task automatic test_wrap();
    logic [10:0] e;
    logic [2:0]  rb;
    logic [2:0]  wb;
    logic [2:0]  prev;
    rb = 3'd4;
    wb = 3'd4;
    for (int i = 0; i < 12; i++) begin
      wb           = wb + 3'd1;
      bus.rq2_wptr = gray(wb);
      step();
      e = pack_exp(gray(rb), rb[1:0], 1'b0, 3'd1, 1'b1, 1'b0);
      nvec++;
      if (obs !== e) begin
        nerr++;
        $display("FAIL wrap_write_%0d got=%b exp=%b", i, obs, e);
      end
      prev     = bus.rptr;
      bus.rinc = 1'b1;
      step();
      bus.rinc = 1'b0;
      rb       = rb + 3'd1;
      e = pack_exp(gray(rb), rb[1:0], 1'b1, 3'd0, 1'b1, 1'b0);
      nvec++;
      if (obs !== e || $countones(prev ^ bus.rptr) != 1) begin
        nerr++;
        $display("FAIL wrap_read_%0d got=%b exp=%b prev_rptr=%b", i, obs, e, prev);
      end
    end
    nvec++;
    if (bus.rptr !== 3'b000) begin
      nerr++;
      $display("FAIL wrap_home got=%b exp=000", bus.rptr);
    end
  endtask

  task automatic test_simultaneous();
    logic [10:0] e;
    bus.rq2_wptr = 3'b001;
    step();
    bus.rinc     = 1'b1;
    bus.rq2_wptr = 3'b011;
    step();
    e = pack_exp(3'b001, 2'd1, 1'b0, 3'd1, 1'b1, 1'b0);
    nvec++;
    if (obs !== e) begin
      nerr++;
      $display("FAIL simul_read_write got=%b exp=%b", obs, e);
    end
    step();
    bus.rinc = 1'b0;
    e = pack_exp(3'b011, 2'd2, 1'b1, 3'd0, 1'b1, 1'b0);
    nvec++;
    if (obs !== e) begin
      nerr++;
      $display("FAIL simul_last_read got=%b exp=%b", obs, e);
    end
  endtask

  initial begin
    nvec = 0;
    nerr = 0;
    test_reset();
    test_single();
    test_async_reset();
    test_back_to_back();
    test_underflow();
    test_wrap();
    test_simultaneous();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
